// File: rtl/mctrl_pkg.sv
// mctrl_pkg: state, ALU, opcode/funct and error-cause encodings shared by the multicycle controller
package mctrl_pkg;
   typedef enum logic [4:0] {
      S_IF = 5'd0, S_ID = 5'd1, S_EXC_MEM = 5'd2, S_EXC_R = 5'd3, S_EXC_I = 5'd4, S_EXC_LUI = 5'd5,
      S_EXC_BEQ = 5'd6, S_EXC_BNE = 5'd7, S_EXC_J = 5'd8, S_EXC_JAL = 5'd9, S_EXC_JR = 5'd10,
      S_EXC_JALR = 5'd11, S_MEM_RD = 5'd12, S_MEM_WD = 5'd13, S_WB_LW = 5'd14, S_WB_R = 5'd15,
      S_WB_I = 5'd16, S_ERROR = 5'd31
   } state_t;
   localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3, ALU_NOR = 4'd4;
   localparam logic [3:0] ALU_SRL = 4'd5, ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_SLL = 4'd8, ALU_SRA = 4'd9;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FUN_SLL = 6'h00, FUN_SRL = 6'h02, FUN_SRA = 6'h03, FUN_JR = 6'h08, FUN_JALR = 6'h09;
   localparam logic [5:0] FUN_ADD = 6'h20, FUN_SUB = 6'h22, FUN_AND = 6'h24, FUN_OR = 6'h25, FUN_XOR = 6'h26;
   localparam logic [5:0] FUN_NOR = 6'h27, FUN_SLT = 6'h2A;
   localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILL = 2'b01, ERR_OVF = 2'b10, ERR_TMO = 2'b11;
   typedef struct packed {
      logic mem_read, mem_write, iord, ir_write, reg_write, pc_write, pc_write_cond, branch, cpu_mio, sor_u;
      logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
      logic [3:0] alu_op;
   } ctrl_t;
   function automatic state_t id_next(input logic [5:0] op, input logic [5:0] fun);
      case (op)
         OP_R: return (fun == FUN_JR) ? S_EXC_JR : (fun == FUN_JALR) ? S_EXC_JALR : S_EXC_R;
         OP_LW, OP_SW: return S_EXC_MEM;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return S_EXC_I;
         OP_LUI: return S_EXC_LUI;
         OP_BEQ: return S_EXC_BEQ;
         OP_BNE: return S_EXC_BNE;
         OP_J: return S_EXC_J;
         OP_JAL: return S_EXC_JAL;
         default: return S_ERROR;
      endcase
   endfunction
   function automatic logic fun_ok(input logic [5:0] fun, input logic en_shift);
      case (fun)
         FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_SLT, FUN_SRL: return 1'b1;
         FUN_SLL, FUN_SRA: return en_shift;
         default: return 1'b0;
      endcase
   endfunction
   function automatic logic is_shift(input logic [5:0] fun);
      return fun == FUN_SLL || fun == FUN_SRL || fun == FUN_SRA;
   endfunction
   function automatic logic [3:0] alu_r(input logic [5:0] fun);
      case (fun)
         FUN_AND: return ALU_AND;
         FUN_OR: return ALU_OR;
         FUN_XOR: return ALU_XOR;
         FUN_NOR: return ALU_NOR;
         FUN_SRL: return ALU_SRL;
         FUN_SUB: return ALU_SUB;
         FUN_SLT: return ALU_SLT;
         FUN_SLL: return ALU_SLL;
         FUN_SRA: return ALU_SRA;
         default: return ALU_ADD;
      endcase
   endfunction
   function automatic logic [3:0] alu_i(input logic [5:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI: return ALU_OR;
         OP_XORI: return ALU_XOR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction
endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: Moore decode of controller state (plus OP/FUN) into the datapath control vector
module mctrl_decode
   import mctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_op,
   input  logic [5:0] i_fun,
   input  logic       i_ready,
   input  logic       i_trap,
   output ctrl_t      o_ctrl
);
   always_comb begin
      o_ctrl = '0;
      o_ctrl.sor_u = !(i_op inside {OP_ANDI, OP_ORI, OP_XORI});
      case (i_state)
         S_IF: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.cpu_mio = 1'b1;
            o_ctrl.ir_write = i_ready;
            o_ctrl.pc_write = i_ready;
            o_ctrl.alu_src_b = 2'b01;
            o_ctrl.alu_op = ALU_ADD;
         end
         S_ID: begin
            o_ctrl.alu_src_b = 2'b11;
            o_ctrl.alu_op = ALU_ADD;
         end
         S_EXC_MEM: begin
            o_ctrl.alu_src_a = 2'b01;
            o_ctrl.alu_src_b = 2'b10;
            o_ctrl.alu_op = ALU_ADD;
         end
         S_EXC_R: begin
            o_ctrl.alu_src_a = is_shift(i_fun) ? 2'b10 : 2'b01;
            o_ctrl.alu_op = alu_r(i_fun);
         end
         S_EXC_I: begin
            o_ctrl.alu_src_a = 2'b01;
            o_ctrl.alu_src_b = 2'b10;
            o_ctrl.alu_op = alu_i(i_op);
         end
         S_EXC_LUI: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.mem_to_reg = 2'b10;
         end
         S_EXC_BEQ, S_EXC_BNE: begin
            o_ctrl.alu_src_a = 2'b01;
            o_ctrl.alu_op = ALU_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.branch = i_state == S_EXC_BEQ;
            o_ctrl.pc_source = 2'b01;
         end
         S_EXC_J: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_source = 2'b10;
         end
         S_EXC_JAL: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_source = 2'b10;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst = 2'b10;
            o_ctrl.mem_to_reg = 2'b11;
         end
         S_EXC_JR: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_source = 2'b11;
         end
         S_EXC_JALR: begin
            o_ctrl.pc_write = 1'b1;
            o_ctrl.pc_source = 2'b11;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst = 2'b01;
            o_ctrl.mem_to_reg = 2'b11;
         end
         S_MEM_RD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord = 1'b1;
            o_ctrl.cpu_mio = 1'b1;
         end
         S_MEM_WD: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.iord = 1'b1;
            o_ctrl.cpu_mio = 1'b1;
         end
         S_WB_LW: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.mem_to_reg = 2'b01;
         end
         S_WB_R: begin
            o_ctrl.reg_write = !i_trap;
            o_ctrl.reg_dst = 2'b01;
         end
         S_WB_I: o_ctrl.reg_write = !i_trap;
         default: o_ctrl = '0;
      endcase
   end
endmodule

// File: rtl/mctrl_param.sv
// mctrl_param: parametrised multicycle MIPS control FSM with MIO handshake, wait timeout and overflow trap
module mctrl_param
   import mctrl_pkg::*;
#(
   parameter int ALU_OP_W    = 3,
   parameter int MIO_TIMEOUT = 16,
   parameter bit EN_OVF_TRAP = 1'b1,
   parameter bit EN_SHIFT    = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         Inst_in,
   input  logic                zero,
   input  logic                overflow,
   input  logic                MIO_ready,
   output logic [4:0]          state_out,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IorD,
   output logic                IRWrite,
   output logic                RegWrite,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                Branch,
   output logic                CPU_MIO,
   output logic                SorU,
   output logic [1:0]          RegDst,
   output logic [1:0]          MemtoReg,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSource,
   output logic [ALU_OP_W-1:0] ALU_operation,
   output logic [1:0]          err_cause
);
   localparam int CW = (MIO_TIMEOUT > 2) ? $clog2(MIO_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'((MIO_TIMEOUT > 0) ? MIO_TIMEOUT - 1 : 0);
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic r_ovf;
   logic [1:0] r_err, w_cause;
   logic [5:0] w_op, w_fun;
   logic w_tmo, w_trap, w_mio, w_unused;
   ctrl_t w_ctrl;
   assign w_op = Inst_in[31:26];
   assign w_fun = Inst_in[5:0];
   assign w_unused = ^{Inst_in[25:6], zero};
   assign w_tmo = (MIO_TIMEOUT > 0) && (r_cnt == TMO_LAST);
   assign w_trap = EN_OVF_TRAP && r_ovf;
   assign w_mio = r_state inside {S_IF, S_MEM_RD, S_MEM_WD};
   // A ready in the last allowed wait cycle takes priority over the timeout
   always_comb begin
      w_next = r_state;
      w_cause = ERR_ILL;
      case (r_state)
         S_IF: begin
            w_next = MIO_ready ? S_ID : w_tmo ? S_ERROR : S_IF;
            w_cause = ERR_TMO;
         end
         S_ID: w_next = id_next(w_op, w_fun);
         S_EXC_MEM: w_next = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WD;
         S_EXC_R: w_next = fun_ok(w_fun, EN_SHIFT) ? S_WB_R : S_ERROR;
         S_EXC_I: w_next = S_WB_I;
         S_MEM_RD: begin
            w_next = MIO_ready ? S_WB_LW : w_tmo ? S_ERROR : S_MEM_RD;
            w_cause = ERR_TMO;
         end
         S_MEM_WD: begin
            w_next = MIO_ready ? S_IF : w_tmo ? S_ERROR : S_MEM_WD;
            w_cause = ERR_TMO;
         end
         S_WB_R, S_WB_I: begin
            w_next = w_trap ? S_ERROR : S_IF;
            w_cause = ERR_OVF;
         end
         S_EXC_LUI, S_EXC_BEQ, S_EXC_BNE, S_EXC_J, S_EXC_JAL, S_EXC_JR, S_EXC_JALR, S_WB_LW: w_next = S_IF;
         default: w_next = S_ERROR;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IF;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_err <= ERR_NONE;
      end else begin
         r_state <= w_next;
         r_cnt <= (w_next != r_state) ? '0 : (w_mio && !MIO_ready) ? r_cnt + 1'b1 : r_cnt;
         if (r_state == S_IF)
            r_ovf <= 1'b0;
         else if ((r_state == S_EXC_R && (w_fun == FUN_ADD || w_fun == FUN_SUB)) || (r_state == S_EXC_I && w_op == OP_ADDI))
            r_ovf <= overflow;
         if (r_err == ERR_NONE && w_next == S_ERROR && r_state != S_ERROR)
            r_err <= w_cause;
      end
   end
   mctrl_decode u_decode (
      .i_state(r_state),
      .i_op(w_op),
      .i_fun(w_fun),
      .i_ready(MIO_ready),
      .i_trap(w_trap),
      .o_ctrl(w_ctrl)
   );
   assign state_out = r_state;
   assign MemRead = w_ctrl.mem_read;
   assign MemWrite = w_ctrl.mem_write;
   assign IorD = w_ctrl.iord;
   assign IRWrite = w_ctrl.ir_write;
   assign RegWrite = w_ctrl.reg_write;
   assign PCWrite = w_ctrl.pc_write;
   assign PCWriteCond = w_ctrl.pc_write_cond;
   assign Branch = w_ctrl.branch;
   assign CPU_MIO = w_ctrl.cpu_mio;
   assign SorU = w_ctrl.sor_u;
   assign RegDst = w_ctrl.reg_dst;
   assign MemtoReg = w_ctrl.mem_to_reg;
   assign ALUSrcA = w_ctrl.alu_src_a;
   assign ALUSrcB = w_ctrl.alu_src_b;
   assign PCSource = w_ctrl.pc_source;
   assign ALU_operation = ALU_OP_W'(w_ctrl.alu_op);
   assign err_cause = r_err;
endmodule

// File: tb/tb_mctrl_param.sv
// tb_mctrl_param: table-driven per-cycle checks of the multicycle controller plus timeout sequences
module tb_mctrl_param;
   logic clk = 1'b0;
   logic reset, zero, overflow, MIO_ready;
   logic [31:0] Inst_in;
   logic [4:0] state_out, ALU_operation;
   logic MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, CPU_MIO, SorU;
   logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, err_cause;
   int n_run = 0;
   int n_fail = 0;
   localparam logic [31:0] I_ADD = 32'h012A4020, I_SRA = 32'h00094083, I_LW = 32'h8D280004;
   localparam logic [31:0] I_SW = 32'hAD280004, I_BEQ = 32'h11090002, I_J = 32'h08000010;
   localparam logic [31:0] I_ADDI = 32'h21280001, I_BADOP = 32'hFC000000, I_BADFN = 32'h0000003F;
   localparam logic [3:0] DC = 4'hF;
   typedef struct packed {
      logic rst;
      logic [31:0] inst;
      logic ovf, rdy;
      logic [4:0] st;
      logic rw, mr, mw, pw, iw;
      logic [3:0] alu;
      logic [1:0] sa, err;
   } vec_t;
   vec_t tbl[$];
   always #5 clk = ~clk;
   mctrl_param #(.ALU_OP_W(5), .MIO_TIMEOUT(16), .EN_OVF_TRAP(1'b1), .EN_SHIFT(1'b1)) dut (
      .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
      .state_out(state_out), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .CPU_MIO(CPU_MIO),
      .SorU(SorU), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .ALU_operation(ALU_operation), .err_cause(err_cause)
   );
   task automatic row(input logic rst, input logic [31:0] inst, input logic ovf, input logic rdy, input logic [4:0] st,
                      input logic rw, input logic mr, input logic mw, input logic pw, input logic iw,
                      input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] err);
      tbl.push_back(vec_t'{rst, inst, ovf, rdy, st, rw, mr, mw, pw, iw, alu, sa, err});
   endtask
   task automatic fetch(input logic [31:0] inst);
      row(0, inst, 0, 1, 5'd0, 0, 1, 0, 1, 1, 4'd2, 2'd0, 2'd0);
      row(0, inst, 0, 1, 5'd1, 0, 0, 0, 0, 0, 4'd2, 2'd0, 2'd0);
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1;
      zero = 1'b0;
      overflow = 1'b0;
      MIO_ready = 1'b1;
      Inst_in = I_ADD;
      fetch(I_ADD);
      row(0, I_ADD, 0, 1, 5'd3, 0, 0, 0, 0, 0, 4'd2, 2'd1, 2'd0);
      row(0, I_ADD, 0, 1, 5'd15, 1, 0, 0, 0, 0, DC, 2'd0, 2'd0);
      fetch(I_SRA);
      row(0, I_SRA, 0, 1, 5'd3, 0, 0, 0, 0, 0, 4'd9, 2'd2, 2'd0);
      row(0, I_SRA, 0, 1, 5'd15, 1, 0, 0, 0, 0, DC, 2'd0, 2'd0);
      fetch(I_LW);
      row(0, I_LW, 0, 1, 5'd2, 0, 0, 0, 0, 0, 4'd2, 2'd1, 2'd0);
      for (int k = 0; k < 5; k++) row(0, I_LW, 0, 0, 5'd12, 0, 1, 0, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_LW, 0, 1, 5'd12, 0, 1, 0, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_LW, 0, 1, 5'd14, 1, 0, 0, 0, 0, DC, 2'd0, 2'd0);
      fetch(I_SW);
      row(0, I_SW, 0, 1, 5'd2, 0, 0, 0, 0, 0, 4'd2, 2'd1, 2'd0);
      row(0, I_SW, 0, 0, 5'd13, 0, 0, 1, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_SW, 0, 1, 5'd13, 0, 0, 1, 0, 0, DC, 2'd0, 2'd0);
      fetch(I_BEQ);
      row(0, I_BEQ, 0, 1, 5'd6, 0, 0, 0, 0, 0, 4'd6, 2'd1, 2'd0);
      fetch(I_J);
      row(0, I_J, 0, 1, 5'd8, 0, 0, 0, 1, 0, DC, 2'd0, 2'd0);
      fetch(I_ADDI);
      row(0, I_ADDI, 1, 1, 5'd4, 0, 0, 0, 0, 0, 4'd2, 2'd1, 2'd0);
      row(0, I_ADDI, 0, 1, 5'd16, 0, 0, 0, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_ADDI, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd2);
      row(1, I_ADDI, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd2);
      fetch(I_BADOP);
      row(0, I_BADOP, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd1);
      row(1, I_BADOP, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd1);
      fetch(I_BADFN);
      row(0, I_BADFN, 0, 1, 5'd3, 0, 0, 0, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_BADFN, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd1);
      row(1, I_BADFN, 0, 1, 5'd31, 0, 0, 0, 0, 0, DC, 2'd0, 2'd1);
      fetch(I_SW);
      row(0, I_SW, 0, 1, 5'd2, 0, 0, 0, 0, 0, 4'd2, 2'd1, 2'd0);
      row(1, I_SW, 0, 0, 5'd13, 0, 0, 1, 0, 0, DC, 2'd0, 2'd0);
      row(0, I_ADD, 0, 1, 5'd0, 0, 1, 0, 1, 1, 4'd2, 2'd0, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         logic [18:0] act, exp, mask;
         reset = tbl[i].rst;
         Inst_in = tbl[i].inst;
         overflow = tbl[i].ovf;
         MIO_ready = tbl[i].rdy;
         @(negedge clk);
         act = {state_out, RegWrite, MemRead, MemWrite, PCWrite, IRWrite, ALU_operation, ALUSrcA, err_cause};
         exp = {tbl[i].st, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].pw, tbl[i].iw, 1'b0, tbl[i].alu, tbl[i].sa, tbl[i].err};
         mask = (tbl[i].alu == DC) ? 19'h7FE03 : 19'h7FFFF;
         check($sformatf("row%0d", i), 32'(act & mask), 32'(exp & mask));
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      overflow = 1'b0;
      Inst_in = I_ADD;
      @(posedge clk);
      #1;
      reset = 1'b0;
      MIO_ready = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check($sformatf("late_wait%0d", k), {27'd0, state_out, PCWrite}, {27'd0, 5'd0, 1'b0});
         @(posedge clk);
         #1;
      end
      MIO_ready = 1'b1;
      @(negedge clk);
      check("late_ready_pcwrite", 32'(PCWrite), 32'd1);
      @(posedge clk);
      #1;
      check("late_ready_state", {25'd0, state_out, err_cause}, {25'd0, 5'd1, 2'd0});
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      MIO_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("tmo_wait%0d", k), {27'd0, state_out, PCWrite}, {27'd0, 5'd0, 1'b0});
         @(posedge clk);
         #1;
      end
      check("tmo_state", {25'd0, state_out, err_cause}, {25'd0, 5'd31, 2'd3});
      MIO_ready = 1'b1;
      @(posedge clk);
      #1;
      check("tmo_absorb", {24'd0, state_out, PCWrite, err_cause}, {24'd0, 5'd31, 1'b0, 2'd3});
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
